// File: rtl/csr_trap_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : csr_trap_unit_if
// Purpose  : EX-stage bundle between the pipeline and csr_trap_unit. It
//            carries the CSR access, the MRET/SRET request, the exception
//            request, the retire and event pulses, and the
//            redirect/stall/privilege responses.
// Modports : slave  - csr_trap_unit side (consumes requests)
//            master - pipeline side (issues requests)
// Revision : 1.0 - initial release
// ============================================================================
interface csr_trap_unit_if #(
  parameter int XLEN    = 32,
  parameter int NUM_HPM = 2
);
  localparam int c_hpm_w = (NUM_HPM > 0) ? NUM_HPM : 1;

  logic               csr_valid;
  logic [1:0]         csr_op;
  logic [11:0]        csr_addr;
  logic [XLEN-1:0]    csr_wsrc;
  logic [1:0]         priv_ret;
  logic               trap_req;
  logic [XLEN-1:0]    trap_cause;
  logic [XLEN-1:0]    trap_pc;
  logic [XLEN-1:0]    trap_tval;
  logic               instr_retire;
  logic [c_hpm_w-1:0] hpm_event;
  logic [XLEN-1:0]    csr_rdata;
  logic               illegal_csr;
  logic               redirect_valid;
  logic [XLEN-1:0]    redirect_pc;
  logic               stall;
  logic [1:0]         priv_mode;

  modport slave (
    input  csr_valid, csr_op, csr_addr, csr_wsrc, priv_ret, trap_req,
           trap_cause, trap_pc, trap_tval, instr_retire, hpm_event,
    output csr_rdata, illegal_csr, redirect_valid, redirect_pc, stall,
           priv_mode
  );

  modport master (
    output csr_valid, csr_op, csr_addr, csr_wsrc, priv_ret, trap_req,
           trap_cause, trap_pc, trap_tval, instr_retire, hpm_event,
    input  csr_rdata, illegal_csr, redirect_valid, redirect_pc, stall,
           priv_mode
  );
endinterface
`default_nettype wire

// File: rtl/csr_trap_unit.sv
`default_nettype none
// ============================================================================
// Module   : csr_trap_unit
// Purpose  : Machine CSR file, CSRRW/CSRRS/CSRRC execution with illegal
//            access detection, three-state trap entry sequencer, MRET/SRET,
//            privilege mode and cycle/instret/hpm counters.
// Ports    : clk, rstn (async, active low)
//            bus (csr_trap_unit_if.slave): CSR access in, csr_rdata and
//            illegal_csr out; trap/priv_ret requests in; redirect_valid,
//            redirect_pc, stall and priv_mode out.
// Options  : CSR_SMODE_EN - adds supervisor CSRs, medeleg, delegated traps
//            and SRET.
// Revision : 1.0 - initial release
// ============================================================================
module csr_trap_unit #(
  parameter int              XLEN        = 32,
  parameter int              NUM_HPM     = 2,
  parameter logic [XLEN-1:0] MTVEC_RESET = '0,
  parameter int              CYCLE_W     = 64
) (
  input  logic           clk,
  input  logic           rstn,
  csr_trap_unit_if.slave bus
);
`ifdef CSR_SMODE_EN
  localparam bit c_smode = 1'b1;
`else
  localparam bit c_smode = 1'b0;
`endif
  localparam int  c_ncnt  = NUM_HPM + 2;   // mcycle, minstret, hpm3..
  localparam bit  c_split = (XLEN == 32);
  localparam int  c_lg    = $clog2(XLEN);
  localparam logic [1:0] c_st_idle = 2'd0, c_st_trap_wr = 2'd1, c_st_trap_jmp = 2'd2;
  localparam logic [1:0] c_op_rw = 2'b01, c_op_rs = 2'b10, c_op_rc = 2'b11;
  localparam logic [1:0] c_prv_u = 2'b00, c_prv_s = 2'b01, c_prv_m = 2'b11;
  localparam logic [11:0] c_a_mstatus = 12'h300, c_a_medeleg = 12'h302,
    c_a_mtvec = 12'h305, c_a_mepc = 12'h341, c_a_mcause = 12'h342,
    c_a_mtval = 12'h343, c_a_sstatus = 12'h100, c_a_stvec = 12'h105,
    c_a_sepc = 12'h141, c_a_scause = 12'h142, c_a_stval = 12'h143,
    c_a_satp = 12'h180, c_a_mcycle = 12'hB00, c_a_mcycleh = 12'hB80,
    c_a_cycle = 12'hC00;
  localparam logic [XLEN-1:0] c_sstatus_mask = XLEN'(12'h122);  // SIE, SPIE, SPP

  logic [1:0]      r_state, r_priv, r_mpp;
  logic            r_mie, r_mpie, r_sie, r_spie, r_spp, r_trap_s, r_redir_valid;
  logic [XLEN-1:0] r_mepc, r_mcause, r_mtval, r_mtvec, r_redir_pc;
  logic [XLEN-1:0] r_sepc, r_scause, r_stval, r_stvec, r_satp, r_medeleg;
  logic [CYCLE_W-1:0] r_cnt [c_ncnt];

  logic [XLEN-1:0]    w_mstatus, w_rdata, w_new, w_cnt_rdata;
  logic [XLEN-1:0]    w_tvec, w_tcause, w_tbase, w_target;
  logic [2*XLEN-1:0]  w_cnt_ext, w_cnt_tmp;
  logic [CYCLE_W-1:0] w_cnt_val, w_cnt_wval;
  logic [c_ncnt-1:0]  w_cnt_sel, w_inc;
  logic w_impl, w_cnt_hit, w_cnt_hi, w_wr_try, w_illegal, w_accept, w_wr_en;
  logic w_mret, w_sret, w_deleg;

  // Counter address offset: mcycle at +0, minstret at +2, hpm3.. from +3.
  function automatic logic [11:0] cnt_off(input int i);
    return (i == 0) ? 12'd0 : 12'(i + 1);
  endfunction

  function automatic logic [XLEN-1:0] tvec_warl(input logic [XLEN-1:0] v);
    return {v[XLEN-1:2], (v[1:0] == 2'b01) ? 2'b01 : 2'b00};
  endfunction

  // MPP=10 is never legal; MPP=01 only exists when S mode does.
  function automatic logic [1:0] mpp_warl(input logic [1:0] v);
    if (v == 2'b10 || (v == c_prv_s && !c_smode)) return c_prv_u;
    return v;
  endfunction

  always_comb begin
    w_mstatus        = '0;
    w_mstatus[1]     = r_sie;
    w_mstatus[3]     = r_mie;
    w_mstatus[5]     = r_spie;
    w_mstatus[7]     = r_mpie;
    w_mstatus[8]     = r_spp;
    w_mstatus[12:11] = r_mpp;
  end

  // Counter decode: selects one counter and which half the address names.
  always_comb begin
    w_cnt_hit = 1'b0;
    w_cnt_hi  = 1'b0;
    w_cnt_sel = '0;
    w_cnt_val = '0;
    for (int i = 0; i < c_ncnt; i++) begin
      if (bus.csr_addr == c_a_mcycle + cnt_off(i) || bus.csr_addr == c_a_cycle + cnt_off(i)) begin
        w_cnt_hit    = 1'b1;
        w_cnt_sel[i] = 1'b1;
        w_cnt_val    = r_cnt[i];
      end
      if (c_split && bus.csr_addr == c_a_mcycleh + cnt_off(i)) begin
        w_cnt_hit    = 1'b1;
        w_cnt_hi     = 1'b1;
        w_cnt_sel[i] = 1'b1;
        w_cnt_val    = r_cnt[i];
      end
    end
    w_cnt_ext                = '0;
    w_cnt_ext[CYCLE_W-1:0]   = w_cnt_val;
    w_cnt_rdata = w_cnt_hi ? w_cnt_ext[2*XLEN-1:XLEN] : w_cnt_ext[XLEN-1:0];
  end

  // Replacement value for a counter write: only the addressed half changes.
  always_comb begin
    w_cnt_tmp = w_cnt_ext;
    if (w_cnt_hi) w_cnt_tmp[2*XLEN-1:XLEN] = w_new;
    else          w_cnt_tmp[XLEN-1:0]      = w_new;
    w_cnt_wval = w_cnt_tmp[CYCLE_W-1:0];
  end

  always_comb begin
    w_impl  = 1'b1;
    w_rdata = '0;
    case (bus.csr_addr)
      c_a_mstatus: w_rdata = w_mstatus;
      c_a_mtvec:   w_rdata = r_mtvec;
      c_a_mepc:    w_rdata = r_mepc;
      c_a_mcause:  w_rdata = r_mcause;
      c_a_mtval:   w_rdata = r_mtval;
      c_a_sstatus: begin w_impl = c_smode; w_rdata = w_mstatus & c_sstatus_mask; end
      c_a_stvec:   begin w_impl = c_smode; w_rdata = r_stvec;   end
      c_a_sepc:    begin w_impl = c_smode; w_rdata = r_sepc;    end
      c_a_scause:  begin w_impl = c_smode; w_rdata = r_scause;  end
      c_a_stval:   begin w_impl = c_smode; w_rdata = r_stval;   end
      c_a_satp:    begin w_impl = c_smode; w_rdata = r_satp;    end
      c_a_medeleg: begin w_impl = c_smode; w_rdata = r_medeleg; end
      default: begin
        w_impl  = w_cnt_hit;
        w_rdata = w_cnt_hit ? w_cnt_rdata : '0;
      end
    endcase
  end

  always_comb begin
    case (bus.csr_op)
      c_op_rw: w_new = bus.csr_wsrc;
      c_op_rs: w_new = w_rdata | bus.csr_wsrc;
      c_op_rc: w_new = w_rdata & ~bus.csr_wsrc;
      default: w_new = w_rdata;
    endcase
  end

  // RS/RC with a zero source never write, so they may read read-only CSRs.
  assign w_wr_try  = (bus.csr_op == c_op_rw) ||
                     ((bus.csr_op == c_op_rs || bus.csr_op == c_op_rc) && bus.csr_wsrc != '0);
  assign w_illegal = bus.csr_valid && (!w_impl || (bus.csr_addr[9:8] > r_priv) ||
                     (bus.csr_addr[11:10] == 2'b11 && w_wr_try));
  assign w_accept  = (r_state == c_st_idle) && !bus.trap_req;
  assign w_wr_en   = w_accept && bus.priv_ret == 2'b00 && bus.csr_valid && !w_illegal && w_wr_try;
  assign w_mret    = w_accept && bus.priv_ret == 2'b01 && r_priv == c_prv_m;
  assign w_sret    = c_smode && w_accept && bus.priv_ret == 2'b10 && r_priv != c_prv_u;
  // Only exception causes below XLEN can index medeleg; interrupts stay in M.
  assign w_deleg   = c_smode && r_priv != c_prv_m && ((bus.trap_cause >> c_lg) == '0) &&
                     r_medeleg[bus.trap_cause[c_lg-1:0]];

  assign w_tvec   = r_trap_s ? r_stvec : r_mtvec;
  assign w_tcause = r_trap_s ? r_scause : r_mcause;
  assign w_tbase  = {w_tvec[XLEN-1:2], 2'b00};
  assign w_target = (w_tvec[1:0] == 2'b01 && w_tcause[XLEN-1]) ?
                    w_tbase + {w_tcause[XLEN-3:0], 2'b00} : w_tbase;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= c_st_idle;     r_priv <= c_prv_m;    r_trap_s <= 1'b0;
      r_mie <= 1'b0;  r_mpie <= 1'b0;  r_mpp <= c_prv_u;
      r_sie <= 1'b0;  r_spie <= 1'b0;  r_spp <= 1'b0;
      r_mepc <= '0;   r_mcause <= '0;  r_mtval <= '0;  r_mtvec <= MTVEC_RESET;
      r_sepc <= '0;   r_scause <= '0;  r_stval <= '0;  r_stvec <= '0;
      r_satp <= '0;   r_medeleg <= '0;
      r_redir_valid <= 1'b0;    r_redir_pc <= '0;
    end else begin
      r_redir_valid <= 1'b0;
      case (r_state)
        c_st_idle: begin
          if (bus.trap_req) begin
            r_state  <= c_st_trap_wr;
            r_trap_s <= w_deleg;
            if (w_deleg) begin
              r_sepc   <= {bus.trap_pc[XLEN-1:2], 2'b00};
              r_scause <= bus.trap_cause;
              r_stval  <= bus.trap_tval;
              r_spie   <= r_sie;
              r_sie    <= 1'b0;
              r_spp    <= r_priv[0];
              r_priv   <= c_prv_s;
            end else begin
              r_mepc   <= {bus.trap_pc[XLEN-1:2], 2'b00};
              r_mcause <= bus.trap_cause;
              r_mtval  <= bus.trap_tval;
              r_mpie   <= r_mie;
              r_mie    <= 1'b0;
              r_mpp    <= r_priv;
              r_priv   <= c_prv_m;
            end
          end else if (w_mret) begin
            r_priv <= r_mpp;  r_mie <= r_mpie;  r_mpie <= 1'b1;  r_mpp <= c_prv_u;
            r_redir_valid <= 1'b1;
            r_redir_pc    <= r_mepc;
          end else if (w_sret) begin
            r_priv <= {1'b0, r_spp};  r_sie <= r_spie;  r_spie <= 1'b1;  r_spp <= 1'b0;
            r_redir_valid <= 1'b1;
            r_redir_pc    <= r_sepc;
          end else if (w_wr_en) begin
            case (bus.csr_addr)
              c_a_mstatus: begin
                r_mie  <= w_new[3];
                r_mpie <= w_new[7];
                r_mpp  <= mpp_warl(w_new[12:11]);
                if (c_smode) begin
                  r_sie <= w_new[1];  r_spie <= w_new[5];  r_spp <= w_new[8];
                end
              end
              c_a_sstatus: begin
                r_sie <= w_new[1];  r_spie <= w_new[5];  r_spp <= w_new[8];
              end
              c_a_mtvec:   r_mtvec   <= tvec_warl(w_new);
              c_a_mepc:    r_mepc    <= {w_new[XLEN-1:2], 2'b00};
              c_a_mcause:  r_mcause  <= w_new;
              c_a_mtval:   r_mtval   <= w_new;
              c_a_stvec:   r_stvec   <= tvec_warl(w_new);
              c_a_sepc:    r_sepc    <= {w_new[XLEN-1:2], 2'b00};
              c_a_scause:  r_scause  <= w_new;
              c_a_stval:   r_stval   <= w_new;
              c_a_satp:    r_satp    <= w_new;
              c_a_medeleg: r_medeleg <= w_new;
              default: ;
            endcase
          end
        end
        c_st_trap_wr: begin
          r_state       <= c_st_trap_jmp;
          r_redir_valid <= 1'b1;
          r_redir_pc    <= w_target;
        end
        c_st_trap_jmp: r_state <= c_st_idle;
        default:       r_state <= c_st_idle;
      endcase
    end
  end

  assign w_inc[0] = 1'b1;
  assign w_inc[1] = bus.instr_retire;
  generate
    if (NUM_HPM > 0) begin : g_hpm_inc
      assign w_inc[c_ncnt-1:2] = bus.hpm_event[NUM_HPM-1:0];
    end
  endgenerate

  // A CSR write to a counter replaces that cycle's increment entirely.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < c_ncnt; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < c_ncnt; i++) begin
        if (w_wr_en && w_cnt_sel[i]) r_cnt[i] <= w_cnt_wval;
        else if (w_inc[i])           r_cnt[i] <= r_cnt[i] + CYCLE_W'(1);
      end
    end
  end

  assign bus.csr_rdata      = w_rdata;
  assign bus.illegal_csr    = w_illegal;
  assign bus.redirect_valid = r_redir_valid;
  assign bus.redirect_pc    = r_redir_pc;
  assign bus.stall          = (r_state == c_st_trap_wr);
  assign bus.priv_mode      = r_priv;
endmodule
`default_nettype wire

// File: tb/tb_csr_trap_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_csr_trap_unit
// Purpose  : Directed self-checking bench for csr_trap_unit (default build,
//            XLEN=32, NUM_HPM=2, MTVEC_RESET=0x100, CYCLE_W=64).
// Revision : 1.0 - initial release
// ============================================================================
module tb_csr_trap_unit;
  localparam logic [1:0] c_rw = 2'b01, c_rs = 2'b10, c_rc = 2'b11;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  csr_trap_unit_if #(.XLEN(32), .NUM_HPM(2)) bus ();

  csr_trap_unit #(
    .XLEN(32), .NUM_HPM(2), .MTVEC_RESET(32'h100), .CYCLE_W(64)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.csr_valid = 1'b0;  bus.csr_op = 2'b00;  bus.csr_addr = 12'h0;  bus.csr_wsrc = '0;
    bus.priv_ret = 2'b00;  bus.trap_req = 1'b0; bus.trap_cause = '0;
    bus.trap_pc = '0;      bus.trap_tval = '0;  bus.instr_retire = 1'b0;
    bus.hpm_event = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_do(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] data);
    bus.csr_valid = 1'b1;  bus.csr_op = op;  bus.csr_addr = addr;  bus.csr_wsrc = data;
    cyc();
    bus.csr_valid = 1'b0;  bus.csr_op = 2'b00;  bus.csr_wsrc = '0;
  endtask

  task automatic csr_read_chk(input string tag, input logic [11:0] addr, input logic [31:0] exp);
    bus.csr_valid = 1'b1;  bus.csr_op = c_rs;  bus.csr_addr = addr;  bus.csr_wsrc = '0;
    @(negedge clk);
    check(tag, bus.csr_rdata, exp);
    check({tag, "_legal"}, bus.illegal_csr, 1'b0);
    cyc();
    bus.csr_valid = 1'b0;  bus.csr_op = 2'b00;
  endtask

  initial begin
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    bus.csr_addr = 12'h300;
    @(negedge clk);
    check("rst_priv", bus.priv_mode, 2'b11);
    check("rst_stall", bus.stall, 1'b0);
    check("rst_redir_valid", bus.redirect_valid, 1'b0);
    check("rst_redir_pc", bus.redirect_pc, 32'h0);
    check("rst_illegal", bus.illegal_csr, 1'b0);
    check("rst_mstatus", bus.csr_rdata, 32'h0);
    bus.csr_addr = 12'h305;
    #1;
    check("rst_mtvec", bus.csr_rdata, 32'h100);
    cyc();
    rstn = 1'b1;
    bus.csr_addr = 12'h0;

    // Basic CSR ops and write masks
    csr_read_chk("mstatus_init", 12'h300, 32'h0);
    csr_read_chk("mtvec_init", 12'h305, 32'h100);
    csr_do(c_rw, 12'h305, 32'h8000_0001);
    csr_read_chk("mtvec_rw", 12'h305, 32'h8000_0001);
    csr_do(c_rs, 12'h300, 32'h8);
    csr_read_chk("mstatus_rs", 12'h300, 32'h8);
    csr_do(c_rc, 12'h300, 32'h8);
    csr_read_chk("mstatus_rc", 12'h300, 32'h0);
    csr_do(c_rw, 12'h305, 32'h8000_0002);
    csr_read_chk("mtvec_mode_warl", 12'h305, 32'h8000_0000);
    csr_do(c_rw, 12'h300, 32'h0000_1000);
    csr_read_chk("mpp_10_dropped", 12'h300, 32'h0);
    csr_do(c_rw, 12'h300, 32'hFFFF_FFFF);
    csr_read_chk("mstatus_field_mask", 12'h300, 32'h0000_1888);
    csr_do(c_rw, 12'h341, 32'h0000_1237);
    csr_read_chk("mepc_low_bits", 12'h341, 32'h0000_1234);

    // Direct-mode trap; the same-cycle CSR write must be dropped
    csr_do(c_rw, 12'h305, 32'h200);
    csr_do(c_rw, 12'h300, 32'h8);
    bus.trap_req = 1'b1;  bus.trap_cause = 32'd2;  bus.trap_pc = 32'h1234;
    bus.trap_tval = 32'hdead;
    bus.csr_valid = 1'b1; bus.csr_op = c_rw;  bus.csr_addr = 12'h305;  bus.csr_wsrc = 32'h999;
    @(negedge clk);
    check("trap_c0_stall", bus.stall, 1'b0);
    cyc();
    idle_inputs();
    @(negedge clk);
    check("trap_wr_stall", bus.stall, 1'b1);
    check("trap_wr_redir", bus.redirect_valid, 1'b0);
    cyc();
    @(negedge clk);
    check("trap_jmp_redir", bus.redirect_valid, 1'b1);
    check("trap_jmp_pc", bus.redirect_pc, 32'h200);
    check("trap_jmp_stall", bus.stall, 1'b0);
    check("trap_priv", bus.priv_mode, 2'b11);
    cyc();
    @(negedge clk);
    check("trap_redir_pulse", bus.redirect_valid, 1'b0);
    cyc();
    csr_read_chk("trap_mepc", 12'h341, 32'h1234);
    csr_read_chk("trap_mcause", 12'h342, 32'd2);
    csr_read_chk("trap_mtval", 12'h343, 32'hdead);
    csr_read_chk("trap_mstatus", 12'h300, 32'h0000_1880);
    csr_read_chk("trap_mtvec_kept", 12'h305, 32'h200);

    // Vectored-mode interrupt
    csr_do(c_rw, 12'h305, 32'h301);
    bus.trap_req = 1'b1;  bus.trap_cause = 32'h8000_0007;  bus.trap_pc = 32'h40;
    cyc();
    idle_inputs();
    cyc();
    @(negedge clk);
    check("vec_redir", bus.redirect_valid, 1'b1);
    check("vec_pc", bus.redirect_pc, 32'h31C);
    cyc();

    // MRET to U mode
    csr_do(c_rw, 12'h300, 32'h80);
    csr_do(c_rw, 12'h341, 32'h1234);
    bus.priv_ret = 2'b01;
    @(negedge clk);
    check("mret_c0_redir", bus.redirect_valid, 1'b0);
    cyc();
    bus.priv_ret = 2'b00;
    @(negedge clk);
    check("mret_redir", bus.redirect_valid, 1'b1);
    check("mret_pc", bus.redirect_pc, 32'h1234);
    check("mret_priv", bus.priv_mode, 2'b00);
    cyc();
    bus.csr_valid = 1'b1;  bus.csr_op = c_rw;  bus.csr_addr = 12'h300;  bus.csr_wsrc = '0;
    @(negedge clk);
    check("u_mstatus_illegal", bus.illegal_csr, 1'b1);
    cyc();
    bus.csr_valid = 1'b0;
    @(negedge clk);
    check("u_mstatus_kept", bus.csr_rdata, 32'h88);
    cyc();
    bus.csr_valid = 1'b1;  bus.csr_op = c_rs;  bus.csr_addr = 12'hC00;  bus.csr_wsrc = '0;
    @(negedge clk);
    check("u_cycle_read_legal", bus.illegal_csr, 1'b0);
    cyc();
    bus.csr_op = c_rw;  bus.csr_wsrc = 32'h5;
    @(negedge clk);
    check("u_cycle_write_illegal", bus.illegal_csr, 1'b1);
    cyc();
    idle_inputs();

    // Exception from U in vectored mode goes to the base
    bus.trap_req = 1'b1;  bus.trap_cause = 32'd2;  bus.trap_pc = 32'h80;
    cyc();
    idle_inputs();
    cyc();
    @(negedge clk);
    check("u_trap_pc", bus.redirect_pc, 32'h300);
    check("u_trap_priv", bus.priv_mode, 2'b11);
    cyc();
    csr_read_chk("u_trap_mstatus", 12'h300, 32'h80);

    // Counters
    csr_do(c_rw, 12'hB00, 32'hFFFF_FFFF);
    csr_read_chk("mcycle_lo_set", 12'hB00, 32'hFFFF_FFFF);
    csr_read_chk("mcycle_hi_wrap", 12'hB80, 32'h1);
    csr_read_chk("mcycle_lo_run", 12'hB00, 32'h1);
    bus.instr_retire = 1'b1;
    csr_do(c_rw, 12'hB02, 32'h55);
    bus.instr_retire = 1'b0;
    csr_read_chk("minstret_write_wins", 12'hB02, 32'h55);
    bus.instr_retire = 1'b1;
    cyc();
    bus.instr_retire = 1'b0;
    csr_read_chk("minstret_inc", 12'hB02, 32'h56);
    bus.hpm_event = 2'b01;
    repeat (3) cyc();
    bus.hpm_event = 2'b00;
    csr_read_chk("hpm3", 12'hB03, 32'h3);
    csr_read_chk("hpm3_shadow", 12'hC03, 32'h3);
    csr_read_chk("hpm4", 12'hB04, 32'h0);

    // Unimplemented addresses
    bus.csr_valid = 1'b1;  bus.csr_op = c_rs;  bus.csr_addr = 12'h7C0;  bus.csr_wsrc = '0;
    @(negedge clk);
    check("unimpl_illegal", bus.illegal_csr, 1'b1);
    check("unimpl_rdata", bus.csr_rdata, 32'h0);
    bus.csr_addr = 12'h105;
    #1;
`ifdef CSR_SMODE_EN
    check("stvec_access", bus.illegal_csr, 1'b0);
`else
    check("stvec_absent", bus.illegal_csr, 1'b1);
`endif
    cyc();
    idle_inputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
